// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-port memory bank between two requesters (r0, r1).
//   Round-robin arbitration every cycle, with an optional lock so that one
//   requester can keep ownership across an atomic multi-cycle sequence such as
//   a read-modify-write. Drives the bank's w_en/addr/d_in and registers the
//   bank's combinational d_out into per-requester read data.
//
// Ports
//   clk, rst_n              clock (posedge) and asynchronous active-low reset
//   i_rN_req                requester N has an access this cycle
//   i_rN_we                 1 = write, 0 = read
//   i_rN_lock               keep ownership after this grant
//   i_rN_addr, i_rN_wdata   access address and write data
//   o_rN_gnt                combinational grant, access completes at the next posedge
//   o_rN_rvalid             registered one-cycle read-data-valid pulse
//   o_rN_rdata              registered read data, holds until the next read completes
//   o_mem_w_en/addr/d_in    to the memory bank
//   i_mem_d_out             from the memory bank (combinational read)
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int word_size = 8,
    parameter int addr_size = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 i_r0_req,
    input  logic                 i_r0_we,
    input  logic                 i_r0_lock,
    input  logic [addr_size-1:0] i_r0_addr,
    input  logic [word_size-1:0] i_r0_wdata,
    output logic                 o_r0_gnt,
    output logic                 o_r0_rvalid,
    output logic [word_size-1:0] o_r0_rdata,

    input  logic                 i_r1_req,
    input  logic                 i_r1_we,
    input  logic                 i_r1_lock,
    input  logic [addr_size-1:0] i_r1_addr,
    input  logic [word_size-1:0] i_r1_wdata,
    output logic                 o_r1_gnt,
    output logic                 o_r1_rvalid,
    output logic [word_size-1:0] o_r1_rdata,

    output logic                 o_mem_w_en,
    output logic [addr_size-1:0] o_mem_addr,
    output logic [word_size-1:0] o_mem_d_in,
    input  logic [word_size-1:0] i_mem_d_out
);

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic                   r_prio;
    logic                   w_nextPrio;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   r_rvalid0;
    logic                   r_rvalid1;
    logic [word_size-1:0]   r_rdata0;
    logic [word_size-1:0]   r_rdata1;

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OPEN;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_prio  <= w_nextPrio;
        end
    end

    // Grant decision. A locked owner is the only candidate; the other side
    // waits even if the round-robin pointer favours it.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            OPEN: begin
                if (i_r0_req && i_r1_req) begin
                    w_gnt0 = ~r_prio;
                    w_gnt1 = r_prio;
                end else if (i_r0_req) begin
                    w_gnt0 = 1'b1;
                end else if (i_r1_req) begin
                    w_gnt1 = 1'b1;
                end
            end
            LOCK0:   w_gnt0 = i_r0_req;
            LOCK1:   w_gnt1 = i_r1_req;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
    end

    // Next state and pointer. The pointer moves on every grant made while
    // open and on the releasing grant of a lock; it holds while a lock
    // continues and on idle cycles. Lock inputs are only looked at when granted.
    always_comb begin
        w_nextState = r_state;
        w_nextPrio  = r_prio;
        if (w_gnt0) begin
            if (r_state == OPEN || !i_r0_lock) begin
                w_nextPrio = 1'b1;
            end
            w_nextState = i_r0_lock ? LOCK0 : OPEN;
        end else if (w_gnt1) begin
            if (r_state == OPEN || !i_r1_lock) begin
                w_nextPrio = 1'b0;
            end
            w_nextState = i_r1_lock ? LOCK1 : OPEN;
        end
    end

    // Bank drive: the mux is steered by the grants alone, so inputs of a
    // port that is not granted can never leak onto the bank.
    always_comb begin
        o_mem_w_en = 1'b0;
        o_mem_addr = '0;
        o_mem_d_in = '0;
        if (w_gnt0) begin
            o_mem_w_en = i_r0_we;
            o_mem_addr = i_r0_addr;
            o_mem_d_in = i_r0_wdata;
        end else if (w_gnt1) begin
            o_mem_w_en = i_r1_we;
            o_mem_addr = i_r1_addr;
            o_mem_d_in = i_r1_wdata;
        end
    end

    // Read responses: capture the bank output at the end of a read grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~i_r0_we;
            r_rvalid1 <= w_gnt1 & ~i_r1_we;
            if (w_gnt0 && !i_r0_we) begin
                r_rdata0 <= i_mem_d_out;
            end
            if (w_gnt1 && !i_r1_we) begin
                r_rdata1 <= i_mem_d_out;
            end
        end
    end

    assign o_r0_gnt    = w_gnt0;
    assign o_r1_gnt    = w_gnt1;
    assign o_r0_rvalid = r_rvalid0;
    assign o_r1_rvalid = r_rvalid1;
    assign o_r0_rdata  = r_rdata0;
    assign o_r1_rdata  = r_rdata1;

endmodule
